// File: rtl/div_clk_prog.sv
//==============================================================================
// Module : div_clk_prog
// Desc   : Multi-channel programmable clock divider; new divisors take effect
//          only at a period boundary. Define DIV_CLK_PROG_SYNC_EN for sync_in.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module div_clk_prog #(
  parameter int NCH       = 4,
  parameter int CW        = 16,
  parameter int DIV_INIT  = 2,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk32M768,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
`ifdef DIV_CLK_PROG_SYNC_EN
  input  logic           sync_in,
`endif
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  localparam logic [CW-1:0] c_one   = CW'(1);
  localparam logic [CW:0]   c_one_w = (CW + 1)'(1);

  logic [NCH-1:0] w_pend;
  logic           w_sync;

`ifdef DIV_CLK_PROG_SYNC_EN
  assign w_sync = sync_in;
`else
  assign w_sync = 1'b0;
`endif

  // Channels beyond NCH never match, so ready stays 1 and the write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == i[CHW-1:0]) cfg_ready = ~w_pend[i];
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam logic [CHW-1:0] c_idx = CHW'(gi);

    logic [CW-1:0] r_cnt, r_div, r_shd;
    logic          r_pend, r_clk, r_tick;
    logic [CW-1:0] w_d, w_p, w_cnt_nx;
    logic [CW:0]   w_half;
    logic          w_wrap, w_acc;

    assign w_acc     = cfg_valid && cfg_ready && (cfg_ch == c_idx);
    assign w_pend[gi] = r_pend;
    assign clk_out[gi] = r_clk;
    assign tick[gi]    = r_tick;

    // r_cnt is the position presented on the next edge; sync restarts at 0.
    always_comb begin
      w_d = r_div;
      w_p = r_cnt;
      if (w_sync) begin
        w_d = r_pend ? r_shd : r_div;
        w_p = '0;
      end
      w_half   = ({1'b0, w_d} + c_one_w) >> 1;
      w_wrap   = (w_d <= c_one) || (w_p == w_d - c_one);
      w_cnt_nx = w_wrap ? '0 : w_p + c_one;
    end

    always_ff @(posedge clk32M768 or posedge rst) begin
      if (rst) begin
        r_cnt  <= '0;
        r_div  <= CW'(DIV_INIT);
        r_shd  <= '0;
        r_pend <= 1'b0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_clk  <= ({1'b0, w_p} < w_half);
        r_tick <= (w_p == '0) && (w_d != '0);
        r_cnt  <= w_cnt_nx;
        if (w_sync) begin
          r_div  <= w_d;
          r_pend <= 1'b0;
        end else if (r_pend && w_wrap) begin
          r_div  <= r_shd;
          r_pend <= 1'b0;
        end
        // Acceptance needs pend=0, so it never collides with an apply.
        if (w_acc) begin
          r_shd  <= cfg_div;
          r_pend <= 1'b1;
        end
      end
    end
  end : g_ch

endmodule

`default_nettype wire

// File: tb/tb_div_clk_prog.sv
//==============================================================================
// Module : tb_div_clk_prog
// Desc   : Self-checking bench for div_clk_prog against a period-start model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_div_clk_prog;

  localparam int NCH      = 4;
  localparam int CW       = 16;
  localparam int DIV_INIT = 2;
  localparam int CHW      = 2;
`ifdef DIV_CLK_PROG_SYNC_EN
  localparam bit SYNC_EN  = 1'b1;
`else
  localparam bit SYNC_EN  = 1'b0;
`endif

  logic           clk32M768 = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           sync_in;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  always #5 clk32M768 = ~clk32M768;

  div_clk_prog #(.NCH(NCH), .CW(CW), .DIV_INIT(DIV_INIT)) dut (
    .clk32M768 (clk32M768),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef DIV_CLK_PROG_SYNC_EN
    .sync_in   (sync_in),
`endif
    .clk_out   (clk_out),
    .tick      (tick)
  );

  // Model: each channel has an active divisor and the cycle its period began.
  int             total = 0;
  int             bad   = 0;
  int             t     = 0;
  int             m_d   [NCH];
  int             m_t0  [NCH];
  int             m_pv  [NCH];
  bit             m_pend[NCH];
  logic [NCH-1:0] exp_clk;
  logic [NCH-1:0] exp_tick;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  function automatic bit model_ready();
    int c = int'(cfg_ch);
    if (c < NCH) return !m_pend[c];
    return 1'b1;
  endfunction

  task automatic model_edge();
    int  c;
    int  k;
    bit  rdy;
    bit  s;
    t++;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_d[i]    = DIV_INIT;
        m_pend[i] = 1'b0;
        m_t0[i]   = t + 1;
      end
      exp_clk  = '0;
      exp_tick = '0;
    end else begin
      c   = int'(cfg_ch);
      rdy = model_ready();
      s   = SYNC_EN && sync_in;
      for (int i = 0; i < NCH; i++) begin
        if (s) begin
          if (m_pend[i]) begin
            m_d[i]    = m_pv[i];
            m_pend[i] = 1'b0;
          end
          m_t0[i] = t;
        end
        k = 0;
        if (m_d[i] == 0) begin
          exp_clk[i]  = 1'b0;
          exp_tick[i] = 1'b0;
        end else begin
          k           = (t - m_t0[i]) % m_d[i];
          exp_clk[i]  = (k < (m_d[i] + 1) / 2);
          exp_tick[i] = (k == 0);
        end
        // A pending divisor starts a fresh period right after the last cycle.
        if (!s && m_pend[i] && (m_d[i] == 0 || k == m_d[i] - 1)) begin
          m_d[i]    = m_pv[i];
          m_pend[i] = 1'b0;
          m_t0[i]   = t + 1;
        end
        if (cfg_valid && rdy && c == i) begin
          m_pend[i] = 1'b1;
          m_pv[i]   = int'(cfg_div);
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk32M768);
    model_edge();
    @(negedge clk32M768);
    check_val("clk_out", 32'(clk_out), 32'(exp_clk));
    check_val("tick", 32'(tick), 32'(exp_tick));
    check_val("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write(input int ch, input int d);
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_div   = CW'(d);
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_val("async_clk_out", 32'(clk_out), 32'd0);
    check_val("async_tick", 32'(tick), 32'd0);
    check_val("async_ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < NCH; i++) begin
      m_pend[i] = 1'b0;
      m_d[i]    = DIV_INIT;
    end
  endtask

  initial begin
    int r;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    sync_in   = 1'b0;
    run(3);
    rst = 1'b0;
    run(8);

    // D=5 on ch1, taken after the current period
    write(1, 5);
    run(14);

    // ch2 silenced, then restarted with D=7
    write(2, 0);
    run(4);
    write(2, 7);
    run(16);

    // second ch1 write refused while pending, ch3 accepted meanwhile
    write(1, 3);
    write(1, 6);
    write(3, 4);
    run(20);

    // sync pulse mid-period with ch0 D=3, ch1 D=4
    write(0, 3);
    run(8);
    write(1, 4);
    run(9);
    sync_in = SYNC_EN;
    cycle();
    sync_in = 1'b0;
    run(10);

    // reset with a write pending on ch0
    write(0, 9);
    async_reset();
    run(2);
    rst = 1'b0;
    run(8);

    for (int n = 0; n < 3000; n++) begin
      cfg_valid = ($urandom_range(0, 99) < 40);
      cfg_ch    = CHW'($urandom_range(0, (1 << CHW) - 1));
      r         = $urandom_range(0, 9);
      if (r == 9) r = $urandom_range(10, 40);
      cfg_div   = CW'(r);
      sync_in   = SYNC_EN && ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
        run($urandom_range(1, 3));
        rst = 1'b0;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
